// File: rtl/crc16_fault_sweep_ctrl.sv
// Sweeps a 16-bit CRC engine through one golden run and 32 single-bit stuck-at runs, then reports detected and escaped faults.
// Optional per-run result stream is enabled by defining CRCSWEEP_RESULT_STREAM_EN.
module crc16_fault_sweep_ctrl #(
    parameter int MSG_WORDS = 4,
    parameter int AW        = $clog2(MSG_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          msg_we,
    input  logic [AW-1:0] msg_addr,
    input  logic [15:0]   msg_wdata,
    output logic          busy,
    output logic          done,
    output logic          eng_rst,
    output logic          eng_en,
    output logic [15:0]   eng_data,
    output logic [15:0]   eng_fault_mask,
    output logic [15:0]   eng_fault_value,
    input  logic [15:0]   eng_crc,
    output logic [15:0]   golden_crc,
    output logic [5:0]    detect_cnt,
    output logic [31:0]   escape_map,
    output logic          res_valid,
    output logic [5:0]    res_idx,
    output logic [15:0]   res_crc
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, CAPT, DONE} state_t;

    localparam logic [AW-1:0] W_LAST = AW'(MSG_WORDS - 1);
    localparam logic [AW-1:0] W_ONE  = AW'(1);
    localparam logic [AW:0]   DEPTH  = (AW + 1)'(MSG_WORDS);
    localparam logic [5:0]    R_LAST = 6'd32;

    state_t        state;
    logic [15:0]   msg [MSG_WORDS];
    logic [AW-1:0] w;
    logic [5:0]    r;
    logic [4:0]    k_cur;

    assign k_cur = 5'(r - 6'd1);

    function automatic logic [15:0] bit_mask(input logic [3:0] b);
        return 16'd1 << b;
    endfunction

    // Buffer is intentionally not reset; it only changes while the sweeper is idle.
    always_ff @(posedge clk) begin
        if (state == IDLE && msg_we && {1'b0, msg_addr} < DEPTH)
            msg[msg_addr] <= msg_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            w               <= '0;
            r               <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            eng_rst         <= 1'b1;
            eng_en          <= 1'b0;
            eng_data        <= '0;
            eng_fault_mask  <= '0;
            eng_fault_value <= '0;
            golden_crc      <= '0;
            detect_cnt      <= '0;
            escape_map      <= '0;
        end else begin
            eng_rst <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= CLR;
                        r               <= '0;
                        detect_cnt      <= '0;
                        escape_map      <= '0;
                        busy            <= 1'b1;
                        eng_rst         <= 1'b1;
                        eng_fault_mask  <= '0;
                        eng_fault_value <= '0;
                    end
                end
                CLR: begin
                    state    <= FEED;
                    w        <= '0;
                    eng_en   <= 1'b1;
                    eng_data <= msg[0];
                end
                FEED: begin
                    if (w == W_LAST) begin
                        state    <= CAPT;
                        eng_en   <= 1'b0;
                        eng_data <= '0;
                    end else begin
                        w        <= w + W_ONE;
                        eng_data <= msg[w + W_ONE];
                    end
                end
                CAPT: begin
                    if (r == 6'd0)
                        golden_crc <= eng_crc;
                    else if (eng_crc == golden_crc)
                        escape_map[k_cur] <= 1'b1;
                    else
                        detect_cnt <= detect_cnt + 6'd1;

                    if (r == R_LAST) begin
                        state           <= DONE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        eng_fault_mask  <= '0;
                        eng_fault_value <= '0;
                    end else begin
                        // Next run r+1 injects fault k = r.
                        state           <= CLR;
                        r               <= r + 6'd1;
                        eng_rst         <= 1'b1;
                        eng_fault_mask  <= bit_mask(r[3:0]);
                        eng_fault_value <= r[4] ? bit_mask(r[3:0]) : 16'h0000;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRCSWEEP_RESULT_STREAM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_crc   <= '0;
        end else begin
            res_valid <= (state == CAPT);
            if (state == CAPT) begin
                res_idx <= r;
                res_crc <= eng_crc;
            end
        end
    end
`else
    assign res_valid = 1'b0;
    assign res_idx   = 6'd0;
    assign res_crc   = 16'h0000;
`endif

endmodule

// File: tb/tb_crc16_fault_sweep_ctrl.sv
// Bench for crc16_fault_sweep_ctrl with a selectable engine stub (constant, XOR-accumulate, CRC-CCITT).
// Expected sweep outcome is computed directly from the message and fault list; honours CRCSWEEP_RESULT_STREAM_EN.
module tb_crc16_fault_sweep_ctrl;
    localparam int MW  = 3;
    localparam int AWB = $clog2(MW);
    localparam int RUN = MW + 2;
    localparam int TOT = 33 * RUN;
`ifdef CRCSWEEP_RESULT_STREAM_EN
    localparam bit STREAM = 1'b1;
`else
    localparam bit STREAM = 1'b0;
`endif

    logic           clk, reset, start, msg_we;
    logic [AWB-1:0] msg_addr;
    logic [15:0]    msg_wdata;
    logic           busy, done, eng_rst, eng_en;
    logic [15:0]    eng_data, eng_fault_mask, eng_fault_value, eng_crc, golden_crc, res_crc;
    logic [5:0]     detect_cnt, res_idx;
    logic [31:0]    escape_map;
    logic           res_valid;

    int n_chk = 0;
    int n_pass = 0;
    int mode = 0;  // 0 constant stub, 1 XOR accumulate, 2 CRC-CCITT
    logic [15:0] mmsg [MW];
    logic [15:0] eng_acc;

    crc16_fault_sweep_ctrl #(.MSG_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .msg_we(msg_we),
        .msg_addr(msg_addr), .msg_wdata(msg_wdata), .busy(busy), .done(done),
        .eng_rst(eng_rst), .eng_en(eng_en), .eng_data(eng_data),
        .eng_fault_mask(eng_fault_mask), .eng_fault_value(eng_fault_value),
        .eng_crc(eng_crc), .golden_crc(golden_crc), .detect_cnt(detect_cnt),
        .escape_map(escape_map), .res_valid(res_valid), .res_idx(res_idx), .res_crc(res_crc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] eng_init();
        return (mode == 1) ? 16'h0000 : 16'hFFFF;
    endfunction

    function automatic logic [15:0] eng_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] x;
        x = c ^ d;
        if (mode == 1) return x;
        for (int i = 0; i < 16; i++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    // Engine stub: stuck-at faults force masked data bits to the fault value.
    always @(posedge clk) begin
        if (eng_rst) eng_acc <= eng_init();
        else if (eng_en)
            eng_acc <= eng_step(eng_acc, (eng_data & ~eng_fault_mask) | (eng_fault_value & eng_fault_mask));
    end
    assign eng_crc = (mode == 0) ? 16'h1234 : eng_acc;

    // CRC the engine should end with for run 0 (golden) or run k+1 (fault k).
    function automatic logic [15:0] model_crc(input int run);
        logic [15:0] m, v, c;
        m = 16'h0;
        v = 16'h0;
        if (run > 0) begin
            m = 16'(1 << ((run - 1) % 16));
            v = (run - 1 >= 16) ? m : 16'h0;
        end
        if (mode == 0) return 16'h1234;
        c = eng_init();
        for (int i = 0; i < MW; i++) c = eng_step(c, (mmsg[i] & ~m) | (v & m));
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load_msg(input int kind);
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            msg_we    = 1'b1;
            msg_addr  = AWB'(i);
            msg_wdata = (kind == 0) ? 16'h0000 : (kind == 1) ? 16'hFFFF : 16'($urandom);
            mmsg[i]   = msg_wdata;
        end
        @(negedge clk);
        msg_we = 1'b0;
    endtask

    // inj: cycle in which start+msg_we are pulsed during the sweep (0 = none)
    task automatic run_sweep(input string name, input bit wr_at_start, input int inj);
        logic [15:0] exp_run [33];
        logic [31:0] esc;
        int          det, r, pos, ridx;
        bit          pulse;
        logic [19:0] exp_ctl;
        logic [31:0] exp_fv;
        logic [15:0] m;
        logic [AWB-1:0] a;

        @(negedge clk);
        start = 1'b1;
        if (wr_at_start) begin
            a = AWB'($urandom_range(MW - 1));
            msg_we = 1'b1;
            msg_addr = a;
            msg_wdata = 16'($urandom);
            mmsg[a] = msg_wdata;
        end
        esc = '0;
        det = 0;
        for (int i = 0; i < 33; i++) exp_run[i] = model_crc(i);
        for (int k = 0; k < 32; k++) begin
            if (exp_run[k + 1] == exp_run[0]) esc[k] = 1'b1;
            else det++;
        end
        @(negedge clk);
        start  = 1'b0;
        msg_we = 1'b0;

        for (int c = 1; c <= TOT + 2; c++) begin
            r   = (c - 1) / RUN;
            pos = (c - 1) % RUN;
            if (c <= TOT) begin
                exp_ctl = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
                if (pos == 0) exp_ctl[17] = 1'b1;
                if (pos >= 1 && pos <= MW) begin
                    exp_ctl[16]   = 1'b1;
                    exp_ctl[15:0] = mmsg[pos - 1];
                end
                m = (r == 0) ? 16'h0 : 16'(1 << ((r - 1) % 16));
                exp_fv = {m, (r >= 17) ? m : 16'h0};
                chk($sformatf("%s_fault@%0d", name, c), {eng_fault_mask, eng_fault_value}, exp_fv);
            end else if (c == TOT + 1) begin
                exp_ctl = {1'b0, 1'b1, 2'b00, 16'h0};
            end else begin
                exp_ctl = 20'h0;
            end
            chk($sformatf("%s_ctl@%0d", name, c), {busy, done, eng_rst, eng_en, eng_data}, exp_ctl);

            pulse = STREAM && (pos == 0) && (c >= RUN + 1) && (c <= TOT + 1);
            if (pulse) begin
                ridx = r - 1;
                chk($sformatf("%s_res@%0d", name, c), {res_valid, res_idx, res_crc},
                    {1'b1, 6'(ridx), exp_run[ridx]});
            end else begin
                chk($sformatf("%s_resv@%0d", name, c), res_valid, 1'b0);
            end

            if (inj != 0 && c == inj) begin
                a = AWB'($urandom_range(MW - 1));
                start = 1'b1;
                msg_we = 1'b1;
                msg_addr = a;
                msg_wdata = ~mmsg[a];
            end
            if (inj != 0 && c == inj + 1) begin
                start = 1'b0;
                msg_we = 1'b0;
            end
            @(negedge clk);
        end

        chk({name, "_golden"}, golden_crc, exp_run[0]);
        chk({name, "_detect"}, detect_cnt, det);
        chk({name, "_escape"}, escape_map, esc);
        chk({name, "_invariant"}, detect_cnt + $countones(escape_map), 32);
        chk({name, "_idle"}, {busy, done, eng_en}, 3'b000);
    endtask

    task automatic reset_mid_sweep();
        int dn;
        dn = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ctl", {busy, done, eng_rst, eng_en, eng_data, eng_fault_mask, eng_fault_value},
            {4'b0010, 48'h0});
        chk("rst_sum", {golden_crc, detect_cnt, escape_map}, 64'h0);
        chk("rst_res", {res_valid, res_idx, res_crc}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel", {busy, done, eng_rst, eng_en}, 4'b0000);
        for (int i = 0; i < TOT + 10; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("rst_nodone", dn, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        msg_we = 1'b0;
        msg_addr = '0;
        msg_wdata = '0;
        #2;
        chk("por_ctl", {busy, done, eng_rst, eng_en, eng_data, eng_fault_mask, eng_fault_value},
            {4'b0010, 48'h0});
        chk("por_sum", {golden_crc, detect_cnt, escape_map}, 64'h0);
        chk("por_res", {res_valid, res_idx, res_crc}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("por_rel", eng_rst, 1'b0);

        mode = 0;
        load_msg(2);
        run_sweep("const", 1'b0, 0);
        chk("const_golden_k", golden_crc, 16'h1234);
        chk("const_escape_k", escape_map, 32'hFFFF_FFFF);
        chk("const_detect_k", detect_cnt, 6'd0);

        mode = 1;
        load_msg(0);
        run_sweep("xor0", 1'b0, 0);
        chk("xor0_escape_k", escape_map, 32'h0000_FFFF);
        chk("xor0_detect_k", detect_cnt, 6'd16);
        load_msg(1);
        run_sweep("xor1", 1'b0, 0);
        chk("xor1_golden_k", golden_crc, 16'hFFFF);
        chk("xor1_escape_k", escape_map, 32'hFFFF_0000);

        mode = 2;
        load_msg(2);
        run_sweep("crc_a", 1'b0, 0);
        load_msg(2);
        run_sweep("crc_b", 1'b1, 40);
        run_sweep("crc_c", 1'b1, TOT + 1);
        load_msg(2);
        run_sweep("crc_d", 1'b0, $urandom_range(TOT, 2));
        run_sweep("crc_e", 1'b0, 0);

        reset_mid_sweep();
        run_sweep("post_rst", 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/crc16_fault_sweep_ctrl.md
# crc16_fault_sweep_ctrl

Sweep sequencer for the 16-bit CRC fault-injection engine. It holds a short message in a local buffer and runs it through the engine once fault-free to get the golden CRC. It then re-runs the message once for each of the 32 single-bit stuck-at faults on the engine data input. Each faulty CRC is compared against the golden CRC, and the block reports which faults the CRC detects and which escape. It sits between the test host (register/bench side) and the CRC engine, and drives all of the engine's control inputs.

## Interface
- MSG_WORDS, 4, message length in 16-bit words; legal range 2..64
- AW, $clog2(MSG_WORDS), message buffer address width (derived, do not override)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  start-sweep request; sampled only in IDLE
- msg_we  in  1  message buffer write strobe; ignored while busy
- msg_addr  in  AW  message buffer write address
- msg_wdata  in  16  message buffer write data
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- eng_rst  out  1  engine clear, registered, drives engine reset
- eng_en  out  1  engine enable
- eng_data  out  16  engine data input (message word)
- eng_fault_mask  out  16  engine fault mask
- eng_fault_value  out  16  engine stuck-at value
- eng_crc  in  16  engine CRC output
- golden_crc  out  16  fault-free CRC of the last sweep
- detect_cnt  out  6  number of detected faults, 0..32
- escape_map  out  32  bit k set = fault k escaped (faulty CRC == golden)
- res_valid  out  1  per-run result strobe (macro-dependent)
- res_idx  out  6  run index of result: 0 = golden, 1..32 = fault k+1
- res_crc  out  16  captured CRC of that run

## Operation
- Fault index k = 0..31: bit = k[3:0], stuck value = k[4]. Order is stuck-at-0 for bits 0..15, then stuck-at-1 for bits 0..15.
- Run r = 0..32:
  - r = 0 is golden: mask = 0, value = 0.
  - r ≥ 1 is fault k = r−1: mask = 1<<bit, value = k[4] ? mask : 0.
  - Mask and value are held constant for the whole run.
- FSM states: IDLE, CLR, FEED, CAPT, DONE.
  - IDLE: when start is seen, clear detect_cnt and escape_map, set r = 0, go to CLR.
  - CLR, 1 cycle: eng_rst = 1, eng_en = 0. Go to FEED with word pointer w = 0.
  - FEED, MSG_WORDS cycles: eng_en = 1, eng_data = msg[w], w increments each cycle. Go to CAPT after w = MSG_WORDS−1.
  - CAPT, 1 cycle: eng_en = 0, sample eng_crc.
    - If r = 0: golden_crc ← eng_crc.
    - Otherwise: if eng_crc == golden_crc, set escape_map[r−1]; else detect_cnt++.
    - If r = 32, go to DONE; otherwise r++ and go to CLR.
  - DONE, 1 cycle: done = 1, then go to IDLE.
- Outside FEED: eng_data = 0, eng_en = 0.
- Message buffer: MSG_WORDS×16 registers.
  - Written only in IDLE, when msg_we = 1.
  - Frozen for the whole sweep; msg_we is ignored while busy.
  - Buffer contents are not cleared by reset.
- Results (golden_crc, detect_cnt, escape_map) stay stable from DONE until the next accepted start.
- Invariant: detect_cnt + popcount(escape_map) = 32 after done.

## Timing
- Reset values:
  - State IDLE.
  - busy = 0, done = 0, eng_en = 0, eng_data = 0, eng_fault_mask = 0, eng_fault_value = 0.
  - eng_rst = 1 while in reset, deasserting on the first clock edge after reset is released.
  - golden_crc = 0, detect_cnt = 0, escape_map = 0, res_valid = 0, res_idx = 0, res_crc = 0.
- Sweep timing (cycle 1 = first cycle after the edge on which start is accepted):
  - Each run lasts MSG_WORDS+2 cycles.
  - The DONE cycle is 33·(MSG_WORDS+2)+1. For MSG_WORDS = 4, done is high in cycle 199.
- busy = 1 in cycles 1..33·(MSG_WORDS+2); busy = 0 in DONE.
- start asserted while busy or in DONE is ignored; it is not queued.
- start together with msg_we in IDLE: the write takes effect, and the sweep uses the new word.
- The engine update from the last FEED word is visible on eng_crc in CAPT. The controller registers it at the CAPT edge.
- Reset mid-sweep: immediate abort to reset values, with no done pulse.

## Configuration
- CRCSWEEP_RESULT_STREAM_EN defined:
  - res_valid pulses for 1 cycle, in the cycle after each CAPT.
  - res_idx = r and res_crc = the captured CRC; 33 pulses per sweep.
- CRCSWEEP_RESULT_STREAM_EN undefined:
  - res_valid, res_idx and res_crc are tied to 0.
  - Summary outputs (golden_crc, detect_cnt, escape_map) are unaffected.

## Test plan
- Constant-stub engine (eng_crc = 16'h1234 always), MSG_WORDS = 4, start → golden_crc = 16'h1234, detect_cnt = 0, escape_map = 32'hFFFF_FFFF, done in cycle 199.
- XOR-accumulate stub engine (clears on eng_rst), MSG_WORDS = 3, message all 16'h0000 → golden_crc = 0, escape_map = 32'h0000_FFFF, detect_cnt = 16.
- Same XOR stub, message all 16'hFFFF → golden_crc = 16'hFFFF, escape_map = 32'hFFFF_0000, detect_cnt = 16.
- Real engine: check eng_fault_mask/eng_fault_value during run r = 20 (fault k = 19, bit 3, stuck-at-1) = 16'h0008/16'h0008. Check eng_en high for exactly MSG_WORDS cycles per run.
- Assert start and msg_we mid-sweep → both ignored, buffer unchanged. Assert reset at cycle 50 → all outputs at reset values, no done pulse, new start runs a clean sweep.
- With CRCSWEEP_RESULT_STREAM_EN: 33 res_valid pulses, res_idx 0..32 in order. Without it: res_valid never asserted.
